// File: rtl/phy_tx_lane_arbiter_pkg.sv
// Shared definitions for the phy_tx lane arbiter: lane count, default idle
// symbol and FSM state encoding.
package phy_tx_lane_arbiter_pkg;

   localparam int         NUM_LANES           = 4;
   localparam logic [7:0] IDLE_SYMBOL_DEFAULT = 8'hBC;

   typedef enum logic [1:0] {
      ST_TRAIN = 2'd0,
      ST_IDLE  = 2'd1,
      ST_BURST = 2'd2
   } state_t;

endpackage

// File: rtl/phy_tx_lane_arbiter_rr_pick4.sv
// rr_pick4: combinational rotating-priority picker over four request bits.
// Lane 'start' has highest priority, then start+1, start+2, start+3 (mod 4).
module rr_pick4 (
   input  logic [3:0] req,
   input  logic [1:0] start,
   output logic       found,
   output logic [1:0] idx
);

   logic [7:0] req_dbl;
   logic [3:0] rot;

   // Duplicate the request vector so a rotation is just a 4-bit window.
   assign req_dbl = {req, req};
   assign rot     = req_dbl[start +: 4];

   // Priority-encode the rotated window, then rotate the offset back.
   always_comb begin
      // NOTE: every output gets a default before the if-chain so no latch is inferred.
      found = |rot;
      idx   = start;
      if (rot[0])      idx = start;
      else if (rot[1]) idx = start + 2'd1;
      else if (rot[2]) idx = start + 2'd2;
      else if (rot[3]) idx = start + 2'd3;
   end

endmodule

// File: rtl/phy_tx_lane_arbiter.sv
// phy_tx_lane_arbiter: merges four byte-wide requester streams into the
// registered phy_tx byte lane. After reset an idle-symbol training window
// runs, then lanes are served round-robin in bursts of up to MAX_BURST bytes.
// Optional feature macro: PHY_TX_LANE_TAG_EN adds the registered lane_id_out.
module phy_tx_lane_arbiter
   import phy_tx_lane_arbiter_pkg::*;
#(
   parameter int         TRAIN_CYCLES = 8,
   parameter int         MAX_BURST    = 4,
   parameter logic [7:0] IDLE_SYMBOL  = IDLE_SYMBOL_DEFAULT
) (
   input  logic       clk_8f,
   input  logic       reset,
   input  logic [7:0] data_in0,
   input  logic [7:0] data_in1,
   input  logic [7:0] data_in2,
   input  logic [7:0] data_in3,
   input  logic       valid_in0,
   input  logic       valid_in1,
   input  logic       valid_in2,
   input  logic       valid_in3,
   output logic       ready_out0,
   output logic       ready_out1,
   output logic       ready_out2,
   output logic       ready_out3,
   output logic [7:0] data_out0,
   output logic       valid_out0
`ifdef PHY_TX_LANE_TAG_EN
   ,
   output logic [1:0] lane_id_out
`endif
);

   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int TW = ($clog2(TRAIN_CYCLES + 1) > 1) ? $clog2(TRAIN_CYCLES + 1) : 1;
   localparam logic [BW-1:0] MAX_BURST_C = BW'(MAX_BURST);
   // With TRAIN_CYCLES=0 the last count is 0, so TRAIN still lasts one cycle.
   localparam logic [TW-1:0] TRAIN_LAST  = (TRAIN_CYCLES == 0) ? TW'(0) : TW'(TRAIN_CYCLES - 1);

   state_t          state, state_nxt;
   logic [1:0]      owner;
   logic [BW-1:0]   burst_cnt, burst_nxt;
   logic [TW-1:0]   train_cnt;
   logic [3:0]      valid_vec;
   logic [7:0]      data_arr [NUM_LANES];
   logic            pick_found;
   logic [1:0]      pick_idx;
   logic            grant_any;
   logic [1:0]      grant_idx;
   logic [3:0]      ready_vec;

   assign valid_vec   = {valid_in3, valid_in2, valid_in1, valid_in0};
   assign data_arr[0] = data_in0;
   assign data_arr[1] = data_in1;
   assign data_arr[2] = data_in2;
   assign data_arr[3] = data_in3;

   // Search begins one past the last owner so every lane gets its turn.
   rr_pick4 u_pick (
      .req   (valid_vec),
      .start (owner + 2'd1),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Grant selection: continue the owner's burst if allowed, else hand over.
   always_comb begin
      grant_any = 1'b0;
      grant_idx = owner;
      burst_nxt = burst_cnt;
      if (reset && state != ST_TRAIN) begin
         if (state == ST_BURST && valid_vec[owner] && burst_cnt < MAX_BURST_C) begin
            grant_any = 1'b1;
            grant_idx = owner;
            burst_nxt = burst_cnt + BW'(1);
         end else if (pick_found) begin
            grant_any = 1'b1;
            grant_idx = pick_idx;
            burst_nxt = BW'(1);
         end
      end
   end

   // State register.
   always_ff @(posedge clk_8f) begin
      // NOTE: reset is sampled on the clock edge (synchronous), and sequential state uses <= only.
      if (!reset) state <= ST_TRAIN;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_TRAIN: if (train_cnt == TRAIN_LAST) state_nxt = ST_IDLE;
         ST_IDLE:  if (grant_any)               state_nxt = ST_BURST;
         ST_BURST: if (!grant_any)              state_nxt = ST_IDLE;
         default:                               state_nxt = ST_TRAIN;
      endcase
   end

   // FSM outputs: one-hot ready toward the granted requester.
   always_comb begin
      ready_vec = 4'b0000;
      if (grant_any) ready_vec[grant_idx] = 1'b1;
   end

   assign ready_out0 = ready_vec[0];
   assign ready_out1 = ready_vec[1];
   assign ready_out2 = ready_vec[2];
   assign ready_out3 = ready_vec[3];

   // Arbitration bookkeeping: training counter, owner pointer, burst length.
   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         train_cnt <= '0;
         owner     <= 2'd3;
         burst_cnt <= '0;
      end else begin
         if (state == ST_TRAIN) train_cnt <= train_cnt + TW'(1);
         if (grant_any) begin
            owner     <= grant_idx;
            burst_cnt <= burst_nxt;
         end
      end
   end

   // Output register feeding the stage-2 flop; idle symbol when nothing moves.
   always_ff @(posedge clk_8f) begin
      if (!reset) begin
         data_out0  <= 8'h00;
         valid_out0 <= 1'b0;
      end else if (grant_any) begin
         data_out0  <= data_arr[grant_idx];
         valid_out0 <= 1'b1;
      end else begin
         data_out0  <= IDLE_SYMBOL;
         valid_out0 <= 1'b0;
      end
   end

`ifdef PHY_TX_LANE_TAG_EN
   // Lane tag travels with the byte and holds while the lane is idle.
   always_ff @(posedge clk_8f) begin
      if (!reset)         lane_id_out <= 2'd0;
      else if (grant_any) lane_id_out <= grant_idx;
   end
`endif

endmodule

// File: tb/tb_phy_tx_lane_arbiter.sv
// Directed bench for phy_tx_lane_arbiter: expected bytes are pushed to a
// scoreboard when stimulus is driven and popped when the output register
// updates. Lane tag checks are compiled when PHY_TX_LANE_TAG_EN is defined.
module tb_phy_tx_lane_arbiter;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
      logic [1:0] id;
   } exp_t;

   logic       clk_8f = 1'b0;
   logic       reset;
   logic [7:0] data_in0, data_in1, data_in2, data_in3;
   logic       valid_in0, valid_in1, valid_in2, valid_in3;
   logic       ready_out0, ready_out1, ready_out2, ready_out3;
   logic [7:0] data_out0;
   logic       valid_out0;
`ifdef PHY_TX_LANE_TAG_EN
   logic [1:0] lane_id_out;
`endif

   logic [3:0] rdy;
   exp_t       sb [$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] base [4];
   int         cnt [4];
   logic [1:0] last_id;

   always #5 clk_8f = ~clk_8f;

   assign rdy = {ready_out3, ready_out2, ready_out1, ready_out0};

   phy_tx_lane_arbiter dut (
      .clk_8f     (clk_8f),
      .reset      (reset),
      .data_in0   (data_in0),
      .data_in1   (data_in1),
      .data_in2   (data_in2),
      .data_in3   (data_in3),
      .valid_in0  (valid_in0),
      .valid_in1  (valid_in1),
      .valid_in2  (valid_in2),
      .valid_in3  (valid_in3),
      .ready_out0 (ready_out0),
      .ready_out1 (ready_out1),
      .ready_out2 (ready_out2),
      .ready_out3 (ready_out3),
      .data_out0  (data_out0),
      .valid_out0 (valid_out0)
`ifdef PHY_TX_LANE_TAG_EN
      ,
      .lane_id_out(lane_id_out)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One clock: drive at negedge, check ready, push expectation, then pop
   // and compare the registered output just after the rising edge.
   task automatic tick(input logic rst, input logic [3:0] vld, input logic [3:0] exp_rdy,
                       input string tag);
      exp_t e;
      exp_t got;
      int   lane;
      @(negedge clk_8f);
      reset     = rst;
      valid_in0 = vld[0];
      valid_in1 = vld[1];
      valid_in2 = vld[2];
      valid_in3 = vld[3];
      data_in0  = base[0] + 8'(cnt[0]);
      data_in1  = base[1] + 8'(cnt[1]);
      data_in2  = base[2] + 8'(cnt[2]);
      data_in3  = base[3] + 8'(cnt[3]);
      #1;
      check_val({tag, " ready"}, {28'd0, rdy}, {28'd0, exp_rdy});
      if (!rst) begin
         e       = '{v: 1'b0, d: 8'h00, id: 2'd0};
         last_id = 2'd0;
      end else if (exp_rdy != 4'b0000) begin
         lane = 0;
         for (int i = 0; i < 4; i++) if (exp_rdy[i]) lane = i;
         e       = '{v: 1'b1, d: base[lane] + 8'(cnt[lane]), id: 2'(lane)};
         last_id = 2'(lane);
         cnt[lane]++;
      end else begin
         e = '{v: 1'b0, d: 8'hBC, id: last_id};
      end
      sb.push_back(e);
      @(posedge clk_8f);
      #1;
      got = sb.pop_front();
      check_val({tag, " valid_out0"}, {31'd0, valid_out0}, {31'd0, got.v});
      check_val({tag, " data_out0"}, {24'd0, data_out0}, {24'd0, got.d});
`ifdef PHY_TX_LANE_TAG_EN
      check_val({tag, " lane_id_out"}, {30'd0, lane_id_out}, {30'd0, got.id});
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      base[0] = 8'hA0;
      base[1] = 8'hB0;
      base[2] = 8'h10;
      base[3] = 8'h30;
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      last_id   = 2'd0;
      reset     = 1'b0;
      valid_in0 = 1'b0; valid_in1 = 1'b0; valid_in2 = 1'b0; valid_in3 = 1'b0;
      data_in0  = 8'h00; data_in1 = 8'h00; data_in2 = 8'h00; data_in3 = 8'h00;

      // Reset for 3 cycles with every requester asking.
      repeat (3) tick(1'b0, 4'b1111, 4'b0000, "reset");
      // Training window: no grants, idle symbol.
      repeat (8) tick(1'b1, 4'b1111, 4'b0000, "train");
      // First grant goes to lane 0 (byte A0).
      tick(1'b1, 4'b1111, 4'b0001, "first_grant");

      // Contention lanes 0/1: A1..A3, B0..B3, A4.
      repeat (3) tick(1'b1, 4'b0011, 4'b0001, "cont_lane0");
      repeat (4) tick(1'b1, 4'b0011, 4'b0010, "cont_lane1");
      tick(1'b1, 4'b0011, 4'b0001, "cont_lane0_again");

      // Nobody requesting: idle symbol, tag holds.
      repeat (2) tick(1'b1, 4'b0000, 4'b0000, "idle");

      // Lone lane 2 streams 0x10..0x17 with no bubble at the burst limit.
      repeat (8) tick(1'b1, 4'b0100, 4'b0100, "lane2_stream");

      // Lane 3 sends two bytes then drops; lane 1 takes over immediately.
      repeat (2) tick(1'b1, 4'b1010, 4'b1000, "lane3_short");
      tick(1'b1, 4'b0010, 4'b0010, "lane1_takeover");
      // Fresh burst count: lane 1 keeps 3 more bytes before lane 0 gets in.
      repeat (3) tick(1'b1, 4'b0011, 4'b0010, "lane1_fresh_burst");
      tick(1'b1, 4'b0011, 4'b0001, "lane0_handover");
      tick(1'b1, 4'b0000, 4'b0000, "no_request");

      // Reset during lane 1's third byte.
      repeat (2) tick(1'b1, 4'b0010, 4'b0010, "lane1_pre_reset");
      tick(1'b0, 4'b0010, 4'b0000, "reset_mid_burst");
      repeat (8) tick(1'b1, 4'b0011, 4'b0000, "retrain");
      tick(1'b1, 4'b0011, 4'b0001, "lane0_priority");
      tick(1'b1, 4'b0000, 4'b0000, "final_idle");

      check_val("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
